// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle between fetch-side producer, the immediate generator and the execute-side consumer.
// The slave view is the generator itself; the master view is whoever drives it.
interface imm_extend_pipe_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
);
  logic             InValid;
  logic             InReady;
  logic [2:0]       ImmSrc;
  logic [24:0]      Instr31_7;
  logic [TAG_W-1:0] InTag;
  logic             OutValid;
  logic             OutReady;
  logic [XLEN-1:0]  ImmOp;
  logic [TAG_W-1:0] OutTag;
  logic             ImmIllegal;

  modport master (
    output InValid, ImmSrc, Instr31_7, InTag, OutReady,
    input  InReady, OutValid, ImmOp, OutTag, ImmIllegal
  );

  modport slave (
    input  InValid, ImmSrc, Instr31_7, InTag, OutReady,
    output InReady, OutValid, ImmOp, OutTag, ImmIllegal
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Registered decode-stage immediate generator with a 2-entry skid buffer.
// InReady is a flop so the upstream ready path never sees downstream combinational logic.
module imm_extend_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 32
) (
  input logic               clk,
  input logic               rst,
  imm_extend_pipe_if.slave  bus
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t           state, nextState;
  logic             inReadyReg;
  logic             inXfer, outXfer;
  logic             loadOutFromIn, loadOutFromSkid, loadSkid;

  logic [31:7]      ins;
  logic [31:0]      raw;
  logic [XLEN-1:0]  immNext;
  logic             illegalNext;

  logic [XLEN-1:0]  outImm, skidImm;
  logic [TAG_W-1:0] outTag, skidTag;
  logic             outIllegal, skidIllegal;

  assign ins = bus.Instr31_7;

  // Every format is first built as a 32-bit value whose bit 31 already holds the
  // correct extension bit (s for signed formats, 0 for zero-extended ones), so a
  // single sign-extending cast covers both XLEN=32 and XLEN=64.
  always_comb begin
    raw         = '0;
    illegalNext = 1'b0;
    case (bus.ImmSrc)
      3'b000: raw = {{20{ins[31]}}, ins[31:20]};
      3'b001: raw = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      3'b010: raw = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      3'b011: raw = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      3'b100: raw = {ins[31:12], 12'b0};
      3'b101: raw = (XLEN == 64) ? {26'b0, ins[25:20]} : {27'b0, ins[24:20]};
      3'b110: raw = {27'b0, ins[19:15]};
      default: illegalNext = 1'b1;
    endcase
    immNext = XLEN'($signed(raw));
  end

  assign inXfer  = bus.InValid & inReadyReg;
  assign outXfer = (state != EMPTY) & bus.OutReady;

  // State register; InReady is precomputed from the next state so it is a flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= EMPTY;
      inReadyReg <= 1'b1;
    end else begin
      state      <= nextState;
      inReadyReg <= (nextState != TWO);
    end
  end

  // Next-state and register load selects.
  always_comb begin
    nextState       = state;
    loadOutFromIn   = 1'b0;
    loadOutFromSkid = 1'b0;
    loadSkid        = 1'b0;
    case (state)
      EMPTY: begin
        if (inXfer) begin
          nextState     = ONE;
          loadOutFromIn = 1'b1;
        end
      end
      ONE: begin
        if (inXfer && outXfer) begin
          loadOutFromIn = 1'b1;
        end else if (inXfer) begin
          nextState = TWO;
          loadSkid  = 1'b1;
        end else if (outXfer) begin
          nextState = EMPTY;
        end
      end
      TWO: begin
        if (outXfer) begin
          nextState       = ONE;
          loadOutFromSkid = 1'b1;
        end
      end
      default: nextState = EMPTY;
    endcase
  end

  // Output register holds the head entry; skid holds the second one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outImm      <= '0;
      outTag      <= '0;
      outIllegal  <= 1'b0;
      skidImm     <= '0;
      skidTag     <= '0;
      skidIllegal <= 1'b0;
    end else begin
      if (loadOutFromIn) begin
        outImm     <= immNext;
        outTag     <= bus.InTag;
        outIllegal <= illegalNext;
      end else if (loadOutFromSkid) begin
        outImm     <= skidImm;
        outTag     <= skidTag;
        outIllegal <= skidIllegal;
      end
      if (loadSkid) begin
        skidImm     <= immNext;
        skidTag     <= bus.InTag;
        skidIllegal <= illegalNext;
      end
    end
  end

  assign bus.InReady    = inReadyReg;
  assign bus.OutValid   = (state != EMPTY);
  assign bus.ImmOp      = outImm;
  assign bus.OutTag     = outTag;
  assign bus.ImmIllegal = outIllegal;

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: one XLEN=32 and one XLEN=64 instance share the same stimulus.
module tb_imm_extend_pipe;

  logic        clk;
  logic        rst;
  logic        inValid;
  logic [2:0]  immSrc;
  logic [31:0] instr;
  logic [31:0] inTag;
  logic        outReady;

  int tests;
  int fails;

  imm_extend_pipe_if #(.XLEN(32), .TAG_W(32)) b32 ();
  imm_extend_pipe_if #(.XLEN(64), .TAG_W(32)) b64 ();

  assign b32.InValid   = inValid;
  assign b32.ImmSrc    = immSrc;
  assign b32.Instr31_7 = instr[31:7];
  assign b32.InTag     = inTag;
  assign b32.OutReady  = outReady;
  assign b64.InValid   = inValid;
  assign b64.ImmSrc    = immSrc;
  assign b64.Instr31_7 = instr[31:7];
  assign b64.InTag     = inTag;
  assign b64.OutReady  = outReady;

  imm_extend_pipe #(.XLEN(32), .TAG_W(32)) dut32 (.clk(clk), .rst(rst), .bus(b32));
  imm_extend_pipe #(.XLEN(64), .TAG_W(32)) dut64 (.clk(clk), .rst(rst), .bus(b64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [2:0] src,
                               input logic [31:0] ins, input logic [31:0] tag);
    inValid = v;
    immSrc  = src;
    instr   = ins;
    inTag   = tag;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    tests    = 0;
    fails    = 0;
    rst      = 1'b1;
    outReady = 1'b0;
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);

    // Reset and idle
    #3;
    checkOutput("rst_outvalid", b32.OutValid, 0);
    checkOutput("rst_immop", b32.ImmOp, 0);
    checkOutput("rst_inready", b32.InReady, 1);
    step();
    step();
    rst = 1'b0;
    step();
    checkOutput("idle_outvalid", b32.OutValid, 0);
    checkOutput("idle_inready", b32.InReady, 1);
    checkOutput("idle_outtag", b32.OutTag, 0);

    // Back-to-back formats at full throughput
    outReady = 1'b1;
    applyStimulus(1'b1, 3'b000, 32'hFFF00093, 32'h100);
    step();
    checkOutput("I_valid", b32.OutValid, 1);
    checkOutput("I_imm", b32.ImmOp, 64'hFFFFFFFF);
    checkOutput("I_tag", b32.OutTag, 32'h100);
    checkOutput("I_imm64", b64.ImmOp, 64'hFFFFFFFFFFFFFFFF);
    applyStimulus(1'b1, 3'b001, 32'hFE112E23, 32'h104);
    step();
    checkOutput("S_imm", b32.ImmOp, 64'hFFFFFFFC);
    checkOutput("S_tag", b32.OutTag, 32'h104);
    applyStimulus(1'b1, 3'b010, 32'hFE000CE3, 32'h108);
    step();
    checkOutput("B_imm", b32.ImmOp, 64'hFFFFFFF8);
    checkOutput("B_tag", b32.OutTag, 32'h108);
    checkOutput("B_imm64", b64.ImmOp, 64'hFFFFFFFFFFFFFFF8);
    applyStimulus(1'b1, 3'b011, 32'h0010006F, 32'h10C);
    step();
    checkOutput("J_imm", b32.ImmOp, 64'h00000800);
    checkOutput("J_tag", b32.OutTag, 32'h10C);
    applyStimulus(1'b1, 3'b100, 32'h123450B7, 32'h110);
    step();
    checkOutput("U_imm", b32.ImmOp, 64'h12345000);
    checkOutput("U_tag", b32.OutTag, 32'h110);
    checkOutput("U_imm64", b64.ImmOp, 64'h0000000012345000);
    checkOutput("U_inready", b32.InReady, 1);
    applyStimulus(1'b1, 3'b101, 32'h03F00013, 32'h114);
    step();
    checkOutput("shamt_imm32", b32.ImmOp, 64'h1F);
    checkOutput("shamt_imm64", b64.ImmOp, 64'h3F);
    applyStimulus(1'b1, 3'b110, 32'h800F8073, 32'h118);
    step();
    checkOutput("csr_imm", b32.ImmOp, 64'h1F);
    checkOutput("csr_illegal", b32.ImmIllegal, 0);
    applyStimulus(1'b1, 3'b111, 32'hFFFFFFFF, 32'h11C);
    step();
    checkOutput("ill_valid", b32.OutValid, 1);
    checkOutput("ill_imm", b32.ImmOp, 0);
    checkOutput("ill_flag", b32.ImmIllegal, 1);
    checkOutput("ill_tag", b32.OutTag, 32'h11C);
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
    step();
    checkOutput("drain_outvalid", b32.OutValid, 0);

    // Backpressure: two accepted, third held until the consumer drains
    outReady = 1'b0;
    applyStimulus(1'b1, 3'b000, 32'h00100093, 32'hA);
    step();
    checkOutput("bp_a_valid", b32.OutValid, 1);
    checkOutput("bp_a_ready", b32.InReady, 1);
    checkOutput("bp_a_imm", b32.ImmOp, 1);
    applyStimulus(1'b1, 3'b000, 32'h00200093, 32'hB);
    step();
    checkOutput("bp_two_ready", b32.InReady, 0);
    checkOutput("bp_two_imm", b32.ImmOp, 1);
    applyStimulus(1'b1, 3'b000, 32'h00300093, 32'hC);
    step();
    checkOutput("bp_hold_ready", b32.InReady, 0);
    checkOutput("bp_hold_imm", b32.ImmOp, 1);
    checkOutput("bp_hold_tag", b32.OutTag, 32'hA);
    outReady = 1'b1;
    step();
    checkOutput("bp_b_imm", b32.ImmOp, 2);
    checkOutput("bp_b_tag", b32.OutTag, 32'hB);
    checkOutput("bp_b_ready", b32.InReady, 1);
    step();
    checkOutput("bp_c_imm", b32.ImmOp, 3);
    checkOutput("bp_c_tag", b32.OutTag, 32'hC);
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
    step();
    checkOutput("bp_end_valid", b32.OutValid, 0);
    checkOutput("bp_end_ready", b32.InReady, 1);

    // Asynchronous reset while both entries are buffered
    outReady = 1'b0;
    applyStimulus(1'b1, 3'b000, 32'h00D00093, 32'hD);
    step();
    applyStimulus(1'b1, 3'b000, 32'h00E00093, 32'hE);
    step();
    applyStimulus(1'b0, 3'b000, 32'h0, 32'h0);
    checkOutput("two_ready", b32.InReady, 0);
    checkOutput("two_valid", b32.OutValid, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("arst_valid", b32.OutValid, 0);
    checkOutput("arst_ready", b32.InReady, 1);
    checkOutput("arst_imm", b32.ImmOp, 0);
    step();
    rst = 1'b0;
    outReady = 1'b1;
    step();
    checkOutput("post_rst_valid", b32.OutValid, 0);
    step();
    checkOutput("post_rst_valid2", b32.OutValid, 0);
    checkOutput("post_rst_ready", b32.InReady, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
